// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: bus widths, CDB source encodings and the
// CDB broadcast record.
package tomasulo_pkg;

  localparam int DATA_W  = 16;
  localparam int TAG_W   = 3;
  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_BCH = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic                valid;
    cdb_src_e            src;
    logic [TAG_W-1:0]    tag;
    logic [DATA_W-1:0]   data;
  } cdb_bcast_t;

  // Successor of a requester index in the 0..2 rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side handshakes and CDB broadcast of the common-data-bus arbiter.
// Handshake: a requester raises *_valid with *_tag/*_data and holds all three
// stable until it sees *_ready high; the result transfers on the clk1 edge
// where valid and ready are both high. The arbiter never raises more than one
// ready at a time, and ready may depend combinationally on the same-cycle valids.
interface cdb_arbiter_if;
  import tomasulo_pkg::*;

  logic              add_valid, mul_valid, bch_valid;
  logic [TAG_W-1:0]  add_tag,   mul_tag,   bch_tag;
  logic [DATA_W-1:0] add_data,  mul_data,  bch_data;
  logic              add_ready, mul_ready, bch_ready;

  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              starve;

  modport slave (
    input  add_valid, mul_valid, bch_valid,
    input  add_tag,   mul_tag,   bch_tag,
    input  add_data,  mul_data,  bch_data,
    output add_ready, mul_ready, bch_ready,
    output cdb_valid, cdb_src, cdb_tag, cdb_data, starve
  );

  modport master (
    output add_valid, mul_valid, bch_valid,
    output add_tag,   mul_tag,   bch_tag,
    output add_data,  mul_data,  bch_data,
    input  add_ready, mul_ready, bch_ready,
    input  cdb_valid, cdb_src, cdb_tag, cdb_data, starve
  );

endinterface

// File: rtl/cdb_pick.sv
// Combinational winner selection for the CDB. CDB_AGE_PRIO_EN selects
// oldest-first (relative to the ROB head); otherwise round-robin from rr_ptr_i.
module cdb_pick
  import tomasulo_pkg::*;
(
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]              head_p_i,
  input  logic [1:0]                    rr_ptr_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [1:0]                    win_o
);

`ifdef CDB_AGE_PRIO_EN
  logic             found;
  logic [TAG_W-1:0] age;
  logic [TAG_W-1:0] best_age;
  logic             unused_rr;

  assign unused_rr = ^rr_ptr_i;

  // Strict less-than keeps the lower index on equal ages: add > mul > bch.
  always_comb begin
    grant_o  = '0;
    win_o    = 2'd0;
    found    = 1'b0;
    age      = '0;
    best_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = tag_i[i] - head_p_i;
      if (valid_i[i] && (!found || age < best_age)) begin
        best_age = age;
        win_o    = 2'(i);
        found    = 1'b1;
      end
    end
    if (found) grant_o[win_o] = 1'b1;
  end
`else
  logic       found;
  logic [1:0] idx;
  logic       unused_age;

  assign unused_age = ^{head_p_i, tag_i};

  always_comb begin
    grant_o = '0;
    win_o   = 2'd0;
    found   = 1'b0;
    idx     = rr_ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        win_o        = idx;
        found        = 1'b1;
      end
      idx = rr_next(idx);
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one of add/mul/bch per cycle and registers the
// winner onto the CDB. Build macro CDB_AGE_PRIO_EN selects oldest-first picking.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] head_p,
  input  logic             flush,
  cdb_arbiter_if.slave     bus
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0]             valid_vec;
  logic [NUM_REQ-1:0][TAG_W-1:0]  tag_vec;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_vec;
  logic [NUM_REQ-1:0]             pick_gnt;
  logic [NUM_REQ-1:0]             gnt;
  logic [1:0]                     win;
  logic [1:0]                     rr_ptr;

  cdb_bcast_t                     cdb_q, cdb_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]  wait_q, wait_d;
  logic                           starve_q, starve_d;

  assign valid_vec = {bus.bch_valid, bus.mul_valid, bus.add_valid};
  assign tag_vec   = {bus.bch_tag,   bus.mul_tag,   bus.add_tag};
  assign data_vec  = {bus.bch_data,  bus.mul_data,  bus.add_data};

  cdb_pick u_pick (
    .valid_i  (valid_vec),
    .tag_i    (tag_vec),
    .head_p_i (head_p),
    .rr_ptr_i (rr_ptr),
    .grant_o  (pick_gnt),
    .win_o    (win)
  );

  // Flush and reset veto the grant without touching the picker.
  assign gnt = pick_gnt & {NUM_REQ{~flush & rst_n}};

  assign bus.add_ready = gnt[SRC_ADD];
  assign bus.mul_ready = gnt[SRC_MUL];
  assign bus.bch_ready = gnt[SRC_BCH];

`ifdef CDB_AGE_PRIO_EN
  assign rr_ptr = 2'd0;
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = rr_next(win);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 2'd0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (|gnt) begin
      cdb_d.valid = 1'b1;
      cdb_d.src   = cdb_src_e'(win);
      cdb_d.tag   = tag_vec[win];
      cdb_d.data  = data_vec[win];
    end
  end

  // A flushed cycle still counts as waiting for a requester holding valid.
  always_comb begin
    wait_d   = wait_q;
    starve_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_vec[i] || gnt[i])  wait_d[i] = '0;
      else if (wait_q[i] != CNT_MAX) wait_d[i] = wait_q[i] + CNT_W'(1);
      if (wait_q[i] == CNT_MAX) starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q    <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      cdb_q    <= cdb_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign bus.cdb_valid = cdb_q.valid;
  assign bus.cdb_src   = cdb_q.src;
  assign bus.cdb_tag   = cdb_q.tag;
  assign bus.cdb_data  = cdb_q.data;
  assign bus.starve    = starve_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// compared against a cycle-level reference model of the arbitration rules.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int LIMIT = 15;
  localparam int EW    = 2 + TAG_W + DATA_W;

  logic             clk1;
  logic             rst_n;
  logic [TAG_W-1:0] head_p;
  logic             flush;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .head_p (head_p),
    .flush  (flush),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- requester state and reference model ----------------
  int                n_checks = 0;
  int                n_errors = 0;
  bit                req_v    [3];
  logic [TAG_W-1:0]  req_tag  [3];
  logic [DATA_W-1:0] req_data [3];

  int                m_rr;
  int                m_wait [3];
  bit                m_cdb_valid;
  bit                m_starve;
  logic [EW-1:0]     m_last;
  logic [EW-1:0]     exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] rdy_vec();
    return {bus.bch_ready, bus.mul_ready, bus.add_ready};
  endfunction

  task automatic model_reset();
    m_rr        = 0;
    m_cdb_valid = 1'b0;
    m_starve    = 1'b0;
    m_last      = '0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  // Returns the requester that should win this cycle, or -1.
  function automatic int pick_winner();
    int best;
    int best_age;
    int age;
    best     = -1;
    best_age = 1000;
    age      = 0;
    if (flush) return -1;
`ifdef CDB_AGE_PRIO_EN
    for (int i = 0; i < 3; i++) begin
      if (req_v[i]) begin
        age = (int'(req_tag[i]) - int'(head_p) + (1 << TAG_W)) % (1 << TAG_W);
        if (age < best_age) begin
          best_age = age;
          best     = i;
        end
      end
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (best < 0 && req_v[(m_rr + k) % 3]) best = (m_rr + k) % 3;
    end
`endif
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.add_valid = req_v[0]; bus.add_tag = req_tag[0]; bus.add_data = req_data[0];
    bus.mul_valid = req_v[1]; bus.mul_tag = req_tag[1]; bus.mul_data = req_data[1];
    bus.bch_valid = req_v[2]; bus.bch_tag = req_tag[2]; bus.bch_data = req_data[2];
  endtask

  task automatic new_req(input int i);
    req_v[i]    = 1'b1;
    req_tag[i]  = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    req_data[i] = DATA_W'($urandom);
  endtask

  // Entered and left at posedge+1. Checks readies mid-cycle, then the
  // registered outputs just after the edge.
  task automatic cycle(output int w);
    logic [2:0] exp_rdy;
    bit         nxt_starve;
    bit         nxt_valid;
    drive();
    #1;
    w       = pick_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("ready", 32'(rdy_vec()), 32'(exp_rdy));

    nxt_starve = 1'b0;
    for (int i = 0; i < 3; i++) if (m_wait[i] == LIMIT) nxt_starve = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!req_v[i] || i == w)  m_wait[i] = 0;
      else if (m_wait[i] < LIMIT) m_wait[i]++;
    end
    nxt_valid = (w >= 0);
    if (nxt_valid) begin
      exp_q.push_back({2'(w), req_tag[w], req_data[w]});
      m_rr = (w + 1) % 3;
    end

    @(posedge clk1);
    #1;
    m_starve    = nxt_starve;
    m_cdb_valid = nxt_valid;
    if (m_cdb_valid) m_last = exp_q.pop_front();
    check("cdb_valid", 32'(bus.cdb_valid), 32'(m_cdb_valid));
    check("starve",    32'(bus.starve),    32'(m_starve));
    check("cdb_src",   32'(bus.cdb_src),   32'(m_last[EW-1 -: 2]));
    check("cdb_tag",   32'(bus.cdb_tag),   32'(m_last[DATA_W +: TAG_W]));
    check("cdb_data",  32'(bus.cdb_data),  32'(m_last[DATA_W-1:0]));
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_cdb_valid"}, 32'(bus.cdb_valid), 32'd0);
    check({pfx, "_cdb_src"},   32'(bus.cdb_src),   32'd0);
    check({pfx, "_cdb_tag"},   32'(bus.cdb_tag),   32'd0);
    check({pfx, "_cdb_data"},  32'(bus.cdb_data),  32'd0);
    check({pfx, "_starve"},    32'(bus.starve),    32'd0);
    check({pfx, "_ready"},     32'(rdy_vec()),     32'd0);
  endtask

  // Holds reset with all valids high, checks, then releases with valids low.
  task automatic do_reset();
    rst_n  = 1'b0;
    flush  = 1'b0;
    head_p = '0;
    for (int i = 0; i < 3; i++) new_req(i);
    drive();
    repeat (2) @(posedge clk1);
    #1;
    check_zero_outputs("rst");
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    drive();
    model_reset();
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int w;
  int burst;
  bit prev_flush;

  initial begin
    do_reset();

    // Single add request.
    req_v[0] = 1'b1; req_tag[0] = 3'd3; req_data[0] = 16'h00AA;
    cycle(w);
    req_v[0] = 1'b0;
    check("single_valid", 32'(bus.cdb_valid), 32'd1);
    check("single_src",   32'(bus.cdb_src),   32'd0);
    check("single_tag",   32'(bus.cdb_tag),   32'd3);
    check("single_data",  32'(bus.cdb_data),  32'h00AA);
    cycle(w);

    do_reset();
`ifdef CDB_AGE_PRIO_EN
    // Oldest relative to head 6: bch (age 0), mul (age 1), add (age 3).
    head_p = 3'd6;
    req_v[0] = 1'b1; req_tag[0] = 3'd1; req_data[0] = 16'h1111;
    req_v[1] = 1'b1; req_tag[1] = 3'd7; req_data[1] = 16'h2222;
    req_v[2] = 1'b1; req_tag[2] = 3'd6; req_data[2] = 16'h3333;
    for (int n = 0; n < 3; n++) begin
      logic [1:0] exp_src [3];
      exp_src = '{2'd2, 2'd1, 2'd0};
      cycle(w);
      if (w >= 0) req_v[w] = 1'b0;
      check("age_order", 32'(bus.cdb_src), 32'(exp_src[n]));
    end
    cycle(w);
`else
    // All three held valid from rr_ptr=0: add, mul, bch, add.
    for (int i = 0; i < 3; i++) new_req(i);
    for (int n = 0; n < 4; n++) begin
      logic [1:0] exp_src [4];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd0};
      cycle(w);
      if (w >= 0) new_req(w);
      check("rr_order", 32'(bus.cdb_src), 32'(exp_src[n]));
    end
`endif

    // Flush with all three valid: no grant, then arbitration resumes unchanged.
    for (int i = 0; i < 3; i++) if (!req_v[i]) new_req(i);
    flush = 1'b1;
    cycle(w);
    check("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    flush = 1'b0;
    cycle(w);
    if (w >= 0) req_v[w] = 1'b0;
`ifndef CDB_AGE_PRIO_EN
    check("flush_rr_hold", 32'(bus.cdb_src), 32'd1);
`endif
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    cycle(w);

    // Starvation: bch held through 20 flush cycles, then granted.
    do_reset();
    new_req(2);
    flush = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cycle(w);
      if (n == 15) check("starve_pre",  32'(bus.starve), 32'd0);
      if (n == 16) check("starve_rise", 32'(bus.starve), 32'd1);
    end
    flush = 1'b0;
    cycle(w);
    if (w >= 0) req_v[w] = 1'b0;
    check("starve_grant", 32'(bus.cdb_src), 32'd2);
    cycle(w);
    check("starve_clear", 32'(bus.starve), 32'd0);

    // Reset mid-stream while a broadcast and starve are both up.
    do_reset();
    req_v[2] = 1'b1; req_tag[2] = 3'd5; req_data[2] = 16'h1234;
    flush = 1'b1;
    repeat (17) cycle(w);
    flush = 1'b0;
    cycle(w);
    check("mid_cdb_valid", 32'(bus.cdb_valid), 32'd1);
    check("mid_starve",    32'(bus.starve),    32'd1);
    for (int i = 0; i < 3; i++) new_req(i);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    drive();
    model_reset();
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;

    // Random traffic with occasional flushes and flush bursts.
    burst      = 0;
    prev_flush = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      head_p = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      if (burst > 0) begin
        flush = 1'b1;
        burst--;
      end else begin
        flush = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 299) == 0) burst = $urandom_range(14, 20);
      end
      for (int i = 0; i < 3; i++) begin
        if (req_v[i] && prev_flush && $urandom_range(0, 3) == 0) req_v[i] = 1'b0;
        else if (!req_v[i] && $urandom_range(0, 1) == 0)          new_req(i);
      end
      cycle(w);
      prev_flush = flush;
      if (w >= 0) req_v[w] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
